// File: rtl/ps2_scancode_receiver.sv
// PS/2 keyboard receiver: synchronizes ps2_clk/data, deframes 11-bit frames,
// folds E0/F0 prefixes into key events and queues them in a small FIFO.
module ps2_scancode_receiver #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       data,
  input  logic       pop,
  input  logic       clear_err,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_release,
  output logic       key_extended,
  output logic       frame_err,
  output logic       overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  logic             clk_s1_q, clk_s2_q, clk_prev_q;
  logic             dat_s1_q, dat_s2_q;
  logic [1:0]       state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_q, par_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic             ext_q, ext_d, brk_q, brk_d;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             frame_err_q, frame_err_d, overflow_q, overflow_d;
  logic [9:0]       mem_q [FIFO_DEPTH];

  logic fall, byte_good, frame_bad, push, pop_ok, push_ok, full, timed_out;
  logic [9:0] head;

  assign fall = clk_prev_q & ~clk_s2_q;

  // Synchronizers idle high so leaving reset never looks like a falling edge.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
    end else begin
      clk_s1_q   <= ps2_clk;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      dat_s1_q   <= data;
      dat_s2_q   <= dat_s1_q;
    end
  end

  // NOTE: every signal written here gets a default first, so no latches infer.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    byte_good = 1'b0;
    frame_bad = 1'b0;
    to_cnt_d  = (state_q == ST_IDLE || fall) ? '0 : to_cnt_q + 1'b1;
    timed_out = (state_q != ST_IDLE) && (to_cnt_q == TO_W'(TIMEOUT));
    case (state_q)
      ST_IDLE: if (fall && !dat_s2_q) begin
        state_d   = ST_DATA;
        bit_cnt_d = '0;
      end
      ST_DATA: if (fall) begin
        shift_d   = {dat_s2_q, shift_q[7:1]};
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
      end
      ST_PARITY: if (fall) begin
        par_d   = dat_s2_q;
        state_d = ST_STOP;
      end
      ST_STOP: if (fall) begin
        state_d = ST_IDLE;
        if (dat_s2_q && (^{shift_q, par_q})) byte_good = 1'b1;
        else                                 frame_bad = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    if (timed_out) begin
      state_d   = ST_IDLE;
      to_cnt_d  = '0;
      byte_good = 1'b0;
      frame_bad = 1'b1;
    end
  end

  always_comb begin
    ext_d = ext_q;
    brk_d = brk_q;
    push  = 1'b0;
    if (frame_bad) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (byte_good) begin
      if (shift_q == 8'hE0)      ext_d = 1'b1;
      else if (shift_q == 8'hF0) brk_d = 1'b1;
      else begin
        push  = 1'b1;
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end
  end

  // A pop in the same cycle frees a slot, so push into a full FIFO still lands.
  assign full        = (count_q == CNT_W'(FIFO_DEPTH));
  assign pop_ok      = pop && (count_q != '0);
  assign push_ok     = push && (!full || pop_ok);
  assign count_d     = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
  assign frame_err_d = frame_bad | (frame_err_q & ~clear_err);
  assign overflow_d  = (push && full && !pop_ok) | (overflow_q & ~clear_err);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      to_cnt_q    <= '0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      to_cnt_q    <= to_cnt_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      count_q     <= count_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // NOTE: FIFO storage is deliberately not reset; the count gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= {ext_q, brk_q, shift_q};
  end

  assign head         = mem_q[rd_ptr_q];
  assign key_valid    = (count_q != '0);
  assign key_code     = key_valid ? head[7:0] : 8'h00;
  assign key_release  = key_valid & head[8];
  assign key_extended = key_valid & head[9];
  assign frame_err    = frame_err_q;
  assign overflow     = overflow_q;

endmodule
